// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: FSM state, default widths
// and the per-lane request record held across the serialised second access.
package legv8_mem_pkg;

    localparam int DEF_ADDR_W = 64;
    localparam int DEF_DATA_W = 64;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } lane_req_t;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bus between the arbiter and the single-ported Data_Memory (combinational read).
interface dmem_port_arbiter_if
    import legv8_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic              control_memwrite;
    logic              control_memread;
    logic [DATA_W-1:0] mem_data_out;

    modport master (
        output mem_address,
        output mem_data_in,
        output control_memwrite,
        output control_memread,
        input  mem_data_out
    );

    modport slave (
        input  mem_address,
        input  mem_data_in,
        input  control_memwrite,
        input  control_memread,
        output mem_data_out
    );

endinterface

// File: rtl/dmem_port_arbiter.sv
// Serialises lane 0 / lane 1 accesses onto one Data_Memory port in program order,
// stalling one cycle on a dual request and returning registered load data.
module dmem_port_arbiter
    import legv8_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic                req_0,
    input  logic                req_1,
    input  logic                we_0,
    input  logic                we_1,
    input  logic [ADDR_W-1:0]   addr_0,
    input  logic [ADDR_W-1:0]   addr_1,
    input  logic [DATA_W-1:0]   wdata_0,
    input  logic [DATA_W-1:0]   wdata_1,
    input  logic                flush,
    output logic                stall,
    output logic                done_0,
    output logic                done_1,
    output logic [DATA_W-1:0]   rdata_0,
    output logic [DATA_W-1:0]   rdata_1,
    output logic [CNT_W-1:0]    conflict_count,
    dmem_port_arbiter_if.master mem
);

    arb_state_e        state_q, state_d;
    lane_req_t         hold_q, hold_d;
    logic              done_0_q, done_0_d;
    logic              done_1_q, done_1_d;
    logic [DATA_W-1:0] rdata_0_q, rdata_0_d;
    logic [DATA_W-1:0] rdata_1_q, rdata_1_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              req_1_eff;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_wr;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // A flush kills the younger lane before it can cause a conflict.
    assign req_1_eff = req_1 & ~flush;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cnt_d     = cnt_q;
        done_0_d  = 1'b0;
        done_1_d  = 1'b0;
        rdata_0_d = rdata_0_q;
        rdata_1_d = rdata_1_q;
        stall     = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_0) begin
                    mem_addr  = addr_0;
                    mem_wdata = wdata_0;
                    mem_wr    = we_0;
                    mem_rd    = ~we_0;
                    done_0_d  = 1'b1;
                    if (!we_0) rdata_0_d = mem.mem_data_out;
                    if (req_1_eff) begin
                        stall        = 1'b1;
                        hold_d.we    = we_1;
                        hold_d.addr  = DEF_ADDR_W'(addr_1);
                        hold_d.wdata = DEF_DATA_W'(wdata_1);
                        state_d      = SECOND;
                        cnt_d        = sat_inc(cnt_q);
                    end
                end else if (req_1_eff) begin
                    mem_addr  = addr_1;
                    mem_wdata = wdata_1;
                    mem_wr    = we_1;
                    mem_rd    = ~we_1;
                    done_1_d  = 1'b1;
                    if (!we_1) rdata_1_d = mem.mem_data_out;
                end
            end
            SECOND: begin
                // Live lane inputs are ignored; only the held lane 1 access runs.
                state_d = IDLE;
                if (!flush) begin
                    mem_addr  = ADDR_W'(hold_q.addr);
                    mem_wdata = DATA_W'(hold_q.wdata);
                    mem_wr    = hold_q.we;
                    mem_rd    = ~hold_q.we;
                    done_1_d  = 1'b1;
                    if (!hold_q.we) rdata_1_d = mem.mem_data_out;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset also discards a pending SECOND access before it can write.
        if (!RESET) begin
            stall     = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
            mem_rd    = 1'b0;
            mem_wr    = 1'b0;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            done_0_q  <= 1'b0;
            done_1_q  <= 1'b0;
            rdata_0_q <= '0;
            rdata_1_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            done_0_q  <= done_0_d;
            done_1_q  <= done_1_d;
            rdata_0_q <= rdata_0_d;
            rdata_1_q <= rdata_1_d;
            cnt_q     <= cnt_d;
        end
    end

    assign mem.mem_address      = mem_addr;
    assign mem.mem_data_in      = mem_wdata;
    assign mem.control_memread  = mem_rd;
    assign mem.control_memwrite = mem_wr;

    assign done_0         = done_0_q;
    assign done_1         = done_1_q;
    assign rdata_0        = rdata_0_q;
    assign rdata_1        = rdata_1_q;
    assign conflict_count = cnt_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed + randomized bench for dmem_port_arbiter against a transaction-level
// model of in-order lane servicing over a small word-addressed memory.
module tb_dmem_port_arbiter;
    import legv8_mem_pkg::*;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int CW = 4;

    logic          CLOCK = 1'b0;
    logic          RESET;
    logic          req_0, req_1, we_0, we_1, flush;
    logic [AW-1:0] addr_0, addr_1;
    logic [DW-1:0] wdata_0, wdata_1;
    logic          stall, done_0, done_1;
    logic [DW-1:0] rdata_0, rdata_1;
    logic [CW-1:0] conflict_count;

    dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .CLOCK          (CLOCK),
        .RESET          (RESET),
        .req_0          (req_0),
        .req_1          (req_1),
        .we_0           (we_0),
        .we_1           (we_1),
        .addr_0         (addr_0),
        .addr_1         (addr_1),
        .wdata_0        (wdata_0),
        .wdata_1        (wdata_1),
        .flush          (flush),
        .stall          (stall),
        .done_0         (done_0),
        .done_1         (done_1),
        .rdata_0        (rdata_0),
        .rdata_1        (rdata_1),
        .conflict_count (conflict_count),
        .mem            (mem_if.master)
    );

    always #5 CLOCK = ~CLOCK;

    // Bench-owned Data_Memory: 32 doublewords, combinational read.
    logic [DW-1:0] mem_arr [0:31];
    logic          mem_init;

    assign mem_if.mem_data_out = mem_arr[mem_if.mem_address[7:3]];

    always @(posedge CLOCK) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem_arr[i] <= '0;
        end else if (mem_if.control_memwrite) begin
            mem_arr[mem_if.mem_address[7:3]] <= mem_if.mem_data_in;
        end
    end

    // Reference model state: expected memory image and outstanding lane 1 access.
    logic [DW-1:0] ref_mem [0:31];
    bit            pend;
    bit            p_we;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wd;
    logic [DW-1:0] e_rd0, e_rd1;
    bit            e_d0, e_d1;
    int            e_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] waddr(input int idx);
        logic [AW-1:0] a;
        a = '0;
        a[7:3] = idx[4:0];
        return a;
    endfunction

    // One clock cycle: drive inputs, check combinational memory side, then registered outputs.
    task automatic cyc(input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input bit r1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input bit fl, input bit rn);
        bit            s_v, s_we, s_lane, e_stall, new_pend, e1;
        logic [AW-1:0] s_a;
        logic [DW-1:0] s_d;
        s_v = 0; s_we = 0; s_lane = 0; e_stall = 0; new_pend = 0;
        s_a = '0; s_d = '0;
        req_0 = r0; we_0 = w0; addr_0 = a0; wdata_0 = d0;
        req_1 = r1; we_1 = w1; addr_1 = a1; wdata_1 = d1;
        flush = fl; RESET = rn;
        #2;
        e1 = r1 && !fl;
        if (rn) begin
            if (pend) begin
                if (!fl) begin
                    s_v = 1; s_lane = 1; s_we = p_we; s_a = p_addr; s_d = p_wd;
                end
            end else if (r0) begin
                s_v = 1; s_lane = 0; s_we = w0; s_a = a0; s_d = d0;
                if (e1) begin
                    e_stall  = 1;
                    new_pend = 1;
                end
            end else if (e1) begin
                s_v = 1; s_lane = 1; s_we = w1; s_a = a1; s_d = d1;
            end
        end
        chk("stall", stall, e_stall);
        chk("memread", mem_if.control_memread, s_v && !s_we);
        chk("memwrite", mem_if.control_memwrite, s_v && s_we);
        chk("mem_address", mem_if.mem_address, s_v ? s_a : '0);
        if (s_v && s_we) chk("mem_data_in", mem_if.mem_data_in, s_d);

        @(posedge CLOCK);
        if (!rn) begin
            pend = 0; e_rd0 = '0; e_rd1 = '0; e_d0 = 0; e_d1 = 0; e_cnt = 0;
        end else begin
            e_d0 = s_v && !s_lane;
            e_d1 = s_v && s_lane;
            if (s_v) begin
                if (s_we) ref_mem[s_a[7:3]] = s_d;
                else if (!s_lane) e_rd0 = ref_mem[s_a[7:3]];
                else e_rd1 = ref_mem[s_a[7:3]];
            end
            if (new_pend) begin
                p_we = w1; p_addr = a1; p_wd = d1;
                e_cnt = (e_cnt >= (1 << CW) - 1) ? (1 << CW) - 1 : e_cnt + 1;
            end
            pend = new_pend;
        end
        #1;
        chk("done_0", done_0, e_d0);
        chk("done_1", done_1, e_d1);
        chk("rdata_0", rdata_0, e_rd0);
        chk("rdata_1", rdata_1, e_rd1);
        chk("conflict_count", conflict_count, 64'(e_cnt));
    endtask

    task automatic idle_cyc(input bit rn);
        cyc(0, 0, '0, '0, 0, 0, '0, '0, 0, rn);
    endtask

    initial begin
        RESET = 0; req_0 = 0; req_1 = 0; we_0 = 0; we_1 = 0; flush = 0;
        addr_0 = '0; addr_1 = '0; wdata_0 = '0; wdata_1 = '0;
        pend = 0; p_we = 0; p_addr = '0; p_wd = '0;
        e_rd0 = '0; e_rd1 = '0; e_d0 = 0; e_d1 = 0; e_cnt = 0;
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        mem_init = 1;
        #1;

        // Reset state
        idle_cyc(0);
        idle_cyc(0);
        mem_init = 0;
        chk("reset_done_0", done_0, 0);
        chk("reset_count", conflict_count, 0);
        idle_cyc(1);

        // Store then load on consecutive cycles, different lanes
        cyc(1, 1, waddr(1), 64'hDEAD, 0, 0, '0, '0, 0, 1);
        cyc(0, 0, '0, '0, 1, 0, waddr(1), '0, 0, 1);
        chk("t1_rdata_1", rdata_1, 64'hDEAD);
        idle_cyc(1);

        // Dual request, same address: store must be visible to the load
        cyc(1, 1, waddr(2), 64'h1234, 1, 0, waddr(2), '0, 0, 1);
        chk("t2_done_0", done_0, 1);
        cyc(1, 1, waddr(9), 64'hBAD, 1, 1, waddr(10), 64'hBAD, 0, 1);
        chk("t2_rdata_1", rdata_1, 64'h1234);
        chk("t2_count", conflict_count, 1);
        idle_cyc(1);

        // Dual request with flush: only lane 0 served
        cyc(1, 0, waddr(2), '0, 1, 1, waddr(5), 64'h55, 1, 1);
        chk("t3_count", conflict_count, 1);
        chk("t3_done_1", done_1, 0);
        idle_cyc(1);

        // Flush during SECOND kills held lane 1 store
        cyc(1, 0, waddr(5), '0, 1, 1, waddr(3), 64'hFF, 0, 1);
        cyc(0, 0, '0, '0, 0, 0, '0, '0, 1, 1);
        chk("t4_mem24", mem_arr[3], 0);
        chk("t4_done_1", done_1, 0);
        cyc(1, 0, waddr(3), '0, 0, 0, '0, '0, 0, 1);

        // Reset during SECOND of a lane 1 store
        cyc(1, 0, waddr(6), '0, 1, 1, waddr(4), 64'h77, 0, 1);
        cyc(0, 0, '0, '0, 0, 0, '0, '0, 0, 0);
        chk("t5_mem32", mem_arr[4], 0);
        chk("t5_done_0", done_0, 0);
        idle_cyc(1);

        // Saturation: 2^CW+3 consecutive dual requests
        idle_cyc(0);
        for (int k = 0; k < (1 << CW) + 3; k++) begin
            cyc(1, 1'($urandom_range(0, 1)), waddr($urandom_range(0, 31)), 64'($urandom),
                1, 1'($urandom_range(0, 1)), waddr($urandom_range(0, 31)), 64'($urandom), 0, 1);
            cyc(1, 0, waddr(0), '0, 1, 0, waddr(0), '0, 0, 1);
        end
        chk("sat_count", conflict_count, (1 << CW) - 1);
        idle_cyc(1);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            cyc(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                waddr($urandom_range(0, 7)), 64'({$urandom, $urandom}),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                waddr($urandom_range(0, 7)), 64'({$urandom, $urandom}),
                1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 31) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
